// File: rtl/l1_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : l1_write_buffer
// Description : Posted, coalescing line write buffer between the L1 physical
//               memory port and physical memory, with read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic              mem_resp,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = ADDR_W - 4;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_RSP  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [DEPTH];
    logic [TAG_W-1:0]    tag_d  [DEPTH];
    logic [LINE_W-1:0]   line_q [DEPTH];
    logic [LINE_W-1:0]   line_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                mem_resp_q, mem_resp_d;
    logic [LINE_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                pmem_read_q, pmem_read_d;
    logic                pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0]   pmem_address_q, pmem_address_d;
    logic [LINE_W-1:0]   pmem_wdata_q, pmem_wdata_d;

    logic [TAG_W-1:0]    req_tag;
    logic                req_valid;
    logic                hit;
    logic [PTR_W-1:0]    hit_idx;
    logic                drain_done;
    logic                rd_miss;
    logic                wr_req;
    logic                draining_hit;
    logic                coalesce;
    logic                alloc;
    logic                unused_addr_bits;

    assign req_tag          = mem_address[ADDR_W-1:4];
    assign unused_addr_bits = ^mem_address[3:0];
    // The cycle carrying mem_resp belongs to the previous request.
    assign req_valid        = (mem_read | mem_write) & ~mem_resp_q;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        tag_d          = tag_q;
        line_d         = line_q;
        head_d         = head_q;
        tail_d         = tail_q;
        mem_resp_d     = 1'b0;
        mem_rdata_d    = mem_rdata_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;

        drain_done   = (state_q == S_WR) && pmem_resp;
        rd_miss      = req_valid && mem_read && !hit;
        wr_req       = req_valid && mem_write && !mem_read;
        draining_hit = hit && (state_q == S_WR) && (hit_idx == head_q);
        coalesce     = wr_req && hit && !draining_hit;
        alloc        = wr_req && !hit && ((count_q != FULL_COUNT) || drain_done);

        if (req_valid && mem_read && hit) begin
            mem_resp_d  = 1'b1;
            mem_rdata_d = line_q[hit_idx];
        end

        // Invalidate before allocating: a full buffer reuses the freed head slot.
        if (drain_done) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        if (coalesce) begin
            line_d[hit_idx] = mem_wdata;
            mem_resp_d      = 1'b1;
        end

        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = req_tag;
            line_d[tail_q]  = mem_wdata;
            tail_d          = tail_q + PTR_W'(1);
            mem_resp_d      = 1'b1;
        end

        count_d = count_q + CNT_W'(alloc) - CNT_W'(drain_done);

        case (state_q)
            S_IDLE: begin
                if (rd_miss) begin
                    state_d        = S_RD;
                    pmem_read_d    = 1'b1;
                    pmem_address_d = {req_tag, 4'b0000};
                end else if (count_q != '0) begin
                    state_d        = S_WR;
                    pmem_write_d   = 1'b1;
                    pmem_address_d = {tag_q[head_q], 4'b0000};
                    // A coalesce into the head on this edge must not be lost.
                    pmem_wdata_d   = (coalesce && (hit_idx == head_q)) ? mem_wdata
                                                                       : line_q[head_q];
                end
            end
            S_RD: begin
                if (pmem_resp) begin
                    state_d     = S_RSP;
                    pmem_read_d = 1'b0;
                    mem_resp_d  = 1'b1;
                    mem_rdata_d = pmem_rdata;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            S_WR: begin
                if (pmem_resp) begin
                    state_d      = S_IDLE;
                    pmem_write_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            valid_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            mem_resp_q     <= mem_resp_d;
            mem_rdata_q    <= mem_rdata_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    // Tag/line payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

    assign mem_resp     = mem_resp_q;
    assign mem_rdata    = mem_rdata_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign empty        = (count_q == '0) && (state_q == S_IDLE);

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(mem_read && mem_write));

endmodule
`default_nettype wire
